// File: rtl/division_unit.sv
// Restoring shift-subtract unsigned divider.
// Produces quotient and remainder in 2*WORD_WIDTH cycles; divide-by-zero returns in one.
module division_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] dividend,
  input  logic [WORD_WIDTH-1:0] divisor,
  output logic                  valid,
  output logic                  div_by_zero,
  output logic [WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WORD_WIDTH) + 1;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_SHIFT,
    DIV_SUB,
    DIV_OUTPUT
  } state_t;

  state_t                state;
  logic [WORD_WIDTH:0]   r;
  logic [WORD_WIDTH-1:0] q;
  logic [WORD_WIDTH-1:0] d;
  logic [CW-1:0]         cnt;

  logic [WORD_WIDTH:0]   d_ext;
  logic                  ge;
  logic [WORD_WIDTH:0]   r_next;
  logic [WORD_WIDTH-1:0] q_next;
  logic [CW-1:0]         cnt_next;
  logic                  done;

  // One restoring step: subtract when the partial remainder covers D.
  always_comb begin
    d_ext    = {1'b0, d};
    ge       = (r >= d_ext);
    r_next   = ge ? (r - d_ext) : r;
    q_next   = {q[WORD_WIDTH-1:1], ge};
    cnt_next = cnt + 1'b1;
    done     = (cnt_next == CW'(WORD_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= DIV_IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      valid       <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (enable) begin
            if (divisor != '0) begin
              q           <= dividend;
              d           <= divisor;
              r           <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              state       <= DIV_SHIFT;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              valid       <= 1'b1;
              state       <= DIV_OUTPUT;
            end
          end
        end
        DIV_SHIFT: begin
          // R msb is always 0 here since R < D before the shift.
          {r, q} <= {r[WORD_WIDTH-1:0], q, 1'b0};
          state  <= DIV_SUB;
        end
        DIV_SUB: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt_next;
          if (done) begin
            quotient  <= q_next;
            remainder <= r_next[WORD_WIDTH-1:0];
            valid     <= 1'b1;
            state     <= DIV_OUTPUT;
          end else begin
            state <= DIV_SHIFT;
          end
        end
        DIV_OUTPUT: begin
          if (!enable) begin
            valid <= 1'b0;
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_division_unit.sv
// Scoreboard bench for division_unit.
// Driver queues expected results; monitor checks each rising valid.
module tb_division_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       valid;
  logic       div_by_zero;
  logic [7:0] quotient;
  logic [7:0] remainder;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         rise;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic prev_v = 1'b0;

  division_unit #(.WORD_WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .dividend    (dividend),
    .divisor     (divisor),
    .valid       (valid),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Monitor: compare every rising valid against the scoreboard head.
  always @(negedge clk) begin
    if (valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency_cycle", cyc, e.rise);
      end
    end
    prev_v <= valid;
  end

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] eq, input logic [7:0] er,
                    input logic pulse);
    exp_t e;
    bit   got;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    enable   = 1'b1;
    e.q    = eq;
    e.r    = er;
    e.z    = (b == 8'd0);
    e.rise = cyc + 1 + ((b == 8'd0) ? 0 : 16);
    sb.push_back(e);
    if (pulse) begin
      @(negedge clk);
      enable = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("result_timeout", 0, 1);
      sb.delete();
    end
    if (pulse) begin
      @(negedge clk);
      chk("pulse_valid_one_cycle", valid, 0);
    end else begin
      repeat (2) @(negedge clk);
      chk("valid_held", valid, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("valid_dropped", valid, 0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    reset_n = 1'b1;

    op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    op(8'd99, 8'd10, 8'd9, 8'd9, 1'b0);
    op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    op(8'd37, 8'd0, 8'd255, 8'd37, 1'b0);
    op(8'd200, 8'd13, 8'd15, 8'd5, 1'b1);

    // Pulse case must leave the unit idle: inputs change, no new result.
    dividend = 8'd11;
    divisor  = 8'd2;
    repeat (20) @(negedge clk);
    chk("idle_after_pulse", valid, 0);

    // Reset partway through a division.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    enable   = 1'b1;
    repeat (5) @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_valid", valid, 0);
    chk("midreset_quotient", quotient, 0);
    chk("midreset_remainder", remainder, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_result_after_reset", valid, 0);
    op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/division_unit.md
# division_unit

Sequential shift-subtract (restoring) unsigned divider, the inverse datapath of the team's shift-add multiplication unit. It accepts a dividend and a divisor under the same enable/valid hold handshake and produces quotient and remainder after a fixed number of cycles. It sits beside the multiplication unit in the arithmetic cluster and reuses its four-state sequencing style.

## Interface
- WORD_WIDTH, 8: bit width of dividend, divisor, quotient and remainder.
- clk  input  1  clock, all state updates on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- enable  input  1  request; sampled in IDLE to start, sampled in OUTPUT to release.
- dividend  input  WORD_WIDTH  unsigned dividend, captured at start.
- divisor  input  WORD_WIDTH  unsigned divisor, captured at start.
- valid  output  1  result available; reset 0.
- div_by_zero  output  1  captured divisor was 0; reset 0; meaningful while valid=1.
- quotient  output  WORD_WIDTH  reset 0.
- remainder  output  WORD_WIDTH  reset 0.

## Operation
- Internal state: partial remainder R (WORD_WIDTH+1 bits), quotient/dividend shifter Q (WORD_WIDTH), divisor register D (WORD_WIDTH), iteration counter (log2(WORD_WIDTH)+1 bits), 2-bit state.
- States: DIV_IDLE, DIV_SHIFT, DIV_SUB, DIV_OUTPUT. Reset state DIV_IDLE.
- DIV_IDLE: if enable=1 and divisor!=0: Q<=dividend, D<=divisor, R<=0, counter<=0, div_by_zero<=0 -> DIV_SHIFT. If enable=1 and divisor==0: quotient<=all ones, remainder<=dividend, div_by_zero<=1, valid<=1 -> DIV_OUTPUT. If enable=0: stay, no register changes.
- DIV_SHIFT: {R,Q} <= {R,Q} << 1 (R[0] takes old Q msb, Q[0]<=0) -> DIV_SUB.
- DIV_SUB: if R >= {1'b0,D}: R <= R - D, Q[0] <= 1; counter <= counter+1. If the incremented counter equals WORD_WIDTH: quotient<=final Q, remainder<=final R[WORD_WIDTH-1:0], valid<=1 -> DIV_OUTPUT; else -> DIV_SHIFT.
- DIV_OUTPUT: valid, quotient, remainder, div_by_zero held stable. If enable=0 at an edge: valid<=0 -> DIV_IDLE; quotient/remainder/div_by_zero keep last values until next start.
- enable is ignored in DIV_SHIFT/DIV_SUB; a deassertion mid-computation does not abort.
- Arithmetic: unsigned only; R never exceeds 2*D-1 before compare, so WORD_WIDTH+1 bits suffice; remainder < divisor always for divisor!=0.
- Reset (reset_n=0 at an edge), in any state including mid-computation: state->DIV_IDLE, all registers and outputs 0.

## Timing
- Edge E0: first edge with enable=1 in DIV_IDLE (start).
- Normal path: valid rises after edge E0+2*WORD_WIDTH (16 edges after E0 for WORD_WIDTH=8), i.e. 2*WORD_WIDTH+1 cycles from start sample to first valid-high cycle.
- Divide-by-zero path: valid rises after E0 itself (1-cycle latency).
- valid stays high until the first edge in DIV_OUTPUT that samples enable=0; it falls at that edge. If enable is already 0 when DIV_OUTPUT is entered, valid is high for exactly one cycle.
- A new operation requires enable to be sampled 1 in DIV_IDLE; since DIV_OUTPUT exits only on enable=0, a held enable never retriggers.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic: reset, enable=1, dividend=100, divisor=7 held -> valid high 16 edges after start edge, quotient=14, remainder=2, div_by_zero=0; valid stays high while enable=1, falls one edge after enable drops.
- Extremes: 255/1 -> q=255 r=0; 255/255 -> q=1 r=0; 5/9 -> q=0 r=5; 0/3 -> q=0 r=0; each with 16-edge latency.
- Divide by zero: dividend=37, divisor=0 -> valid at the edge after start, div_by_zero=1, quotient=255, remainder=37.
- Pulse enable: enable high for one cycle only, dividend=200, divisor=13 -> valid high exactly one cycle, q=15 r=5, then DIV_IDLE.
- Reset mid-operation: start 100/7, assert reset_n=0 at edge 6 -> next cycle valid=0, quotient=0, remainder=0; after release, start 50/6 -> q=8 r=2 with full latency.
- Back-to-back: after result of 100/7 and enable low one cycle, start 99/10 -> q=9 r=9, no stale bits from previous operation.
